serial_pattern_tx: RTL and testbench
====================================

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the maximum frame length in bits and the load_data width.
REQ-002 SHALL have parameter GAP, default 2, meaning the number of idle cycles after each frame; 0 is legal.
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port load_valid  input  1  upstream offers a frame.
REQ-006 SHALL have port load_ready  output  1  block can accept a frame.
REQ-007 SHALL have port load_data  input  WIDTH  frame payload.
REQ-008 SHALL have port load_len  input  $clog2(WIDTH+1)  number of bits to send.
REQ-009 SHALL have port x  output  1  serial bit stream, driving a detector-style FSM input.
REQ-010 SHALL have port x_valid  output  1  x carries a frame bit this cycle.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse coinciding with the last bit of a frame.

Function
REQ-012 SHALL implement states IDLE, SEND and GAP; any unused encoding SHALL go to IDLE on the next edge.
REQ-013 SHALL drive load_ready=1 only in IDLE; it SHALL be 0 in SEND and GAP.
REQ-014 SHALL accept a frame on a rising edge where load_valid=1 and load_ready=1; accept edge = cycle k.
REQ-015 SHALL capture load_data and the effective length L at acceptance; later input changes SHALL have no effect on the frame.
REQ-016 SHALL set effective length L: load_len=0 gives L=WIDTH; load_len>WIDTH gives L=WIDTH (clamp); otherwise L=load_len.
REQ-017 SHALL ignore load_valid when load_ready=0, with no capture and no state change.
REQ-018 SHALL send bits MSB-first from load_data[L-1] down to load_data[0]: in cycle k+1+i, x=load_data[L-1-i] and x_valid=1, for i=0..L-1.
REQ-019 SHALL register x, x_valid and frame_done; no combinational path from inputs to them.
REQ-020 SHALL assert frame_done for exactly cycle k+L only.
REQ-021 SHALL, after the last bit, go to GAP for GAP cycles (x=0, x_valid=0) when GAP>0, or go directly to IDLE when GAP=0.
REQ-022 SHALL make load_ready high again in cycle k+L+GAP+1, so the earliest next acceptance is at that edge.
REQ-023 SHALL force x=0 whenever x_valid=0.
REQ-024 SHALL use a bit counter wide enough for WIDTH with no wrap-around; the counter SHALL be reloaded on every acceptance.

Reset
REQ-025 SHALL, on reset=0 and independent of clk, immediately enter IDLE and force x=0, x_valid=0 and frame_done=0.
REQ-026 SHALL hold load_ready=1 while in reset and after release (IDLE).
REQ-027 SHALL allow acceptance at the first rising edge after reset returns to 1.
REQ-028 SHALL, on reset during SEND or GAP, abort the frame, emit no frame_done and not resume the frame after release.

Verification (WIDTH=8, GAP=2 unless stated)
REQ-029 SHALL cover: reset=0 for 10 ns, then release; load_data=8'b1011_0010, load_len=8 -> x=1,0,1,1,0,0,1,0 in k+1..k+8; frame_done only in k+8; load_ready=1 again in k+11.
REQ-030 SHALL cover: load_data=8'hF5, load_len=3 -> x=1,0,1 in k+1..k+3; x_valid=0 from k+4.
REQ-031 SHALL cover: load_len=0 and then load_len=12 -> each frame sends 8 bits; frame_done in k+8.
REQ-032 SHALL cover: load_valid held at 1 with changing load_data during SEND and GAP -> current frame bits unchanged; the second frame is accepted exactly at edge k+L+3.
REQ-033 SHALL cover: reset=0 asynchronously mid-cycle during bit 4 -> x, x_valid fall immediately; no frame_done; load_ready=1; a new frame is accepted at the first edge after release.
REQ-034 SHALL cover: GAP=0 build with back-to-back frames, load_len=4 -> load_ready in k+5, and exactly one x_valid=0 cycle between frames.

Source files
------------

// File: rtl/serial_pattern_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : serial_pattern_tx                                               |
// | Brief  : Accepts a parallel frame of up to WIDTH bits and shifts it out  |
// |          MSB-first on a registered serial line, followed by GAP idle     |
// |          cycles before the next frame can be accepted.                   |
// | Ports  : clk        - single clock, rising-edge                          |
// |          reset      - asynchronous, active-low reset                     |
// |          load_valid - upstream offers a frame                            |
// |          load_ready - high only in IDLE; frame taken when both high      |
// |          load_data  - frame payload (WIDTH bits)                         |
// |          load_len   - bits to send; 0 or >WIDTH means WIDTH              |
// |          x          - serial bit stream (0 whenever x_valid is 0)        |
// |          x_valid    - x carries a frame bit this cycle                   |
// |          frame_done - one-cycle pulse alongside the last bit of a frame  |
// | Rev    : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module serial_pattern_tx #(
   parameter int WIDTH = 8,
   parameter int GAP   = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       load_valid,
   output logic                       load_ready,
   input  logic [WIDTH-1:0]           load_data,
   input  logic [$clog2(WIDTH+1)-1:0] load_len,
   output logic                       x,
   output logic                       x_valid,
   output logic                       frame_done
);

   localparam int LW = $clog2(WIDTH + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [LW-1:0] WIDTH_L  = LW'(WIDTH);
   localparam logic [LW-1:0] ONE_L    = LW'(1);
   localparam logic [GW-1:0] GONE_L   = GW'(1);
   localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] data_q, data_nx;
   logic [LW-1:0]    idx_q, idx_nx;     // index of the bit currently on x
   logic [GW-1:0]    gap_q, gap_nx;     // idle cycles remaining minus one
   logic             x_nx, x_valid_nx, frame_done_nx;
   logic [LW-1:0]    len_eff;
   logic [WIDTH-1:0] shifted;

   // Zero and over-long lengths both mean a full-width frame.
   assign len_eff    = ((load_len == '0) || (load_len > WIDTH_L)) ? WIDTH_L : load_len;
   assign load_ready = (state == ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         data_q     <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         x          <= 1'b0;
         x_valid    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         data_q     <= data_nx;
         idx_q      <= idx_nx;
         gap_q      <= gap_nx;
         x          <= x_nx;
         x_valid    <= x_valid_nx;
         frame_done <= frame_done_nx;
      end
   end

   // The first bit is launched on the acceptance edge itself, so the serial
   // outputs lead the state by one cycle: idx_q names the bit already on x.
   always_comb begin
      state_nx      = state;
      data_nx       = data_q;
      idx_nx        = idx_q;
      gap_nx        = gap_q;
      x_nx          = 1'b0;
      x_valid_nx    = 1'b0;
      frame_done_nx = 1'b0;
      shifted       = '0;
      case (state)
         ST_IDLE: begin
            if (load_valid) begin
               shifted       = load_data >> (len_eff - ONE_L);
               state_nx      = ST_SEND;
               data_nx       = load_data;
               idx_nx        = len_eff - ONE_L;
               x_nx          = shifted[0];
               x_valid_nx    = 1'b1;
               frame_done_nx = (len_eff == ONE_L);
            end
         end
         ST_SEND: begin
            if (idx_q == '0) begin
               // Last bit is on the line this cycle.
               if (GAP > 0) begin
                  state_nx = ST_GAP;
                  gap_nx   = GAP_LAST;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               shifted       = data_q >> (idx_q - ONE_L);
               idx_nx        = idx_q - ONE_L;
               x_nx          = shifted[0];
               x_valid_nx    = 1'b1;
               frame_done_nx = (idx_q == ONE_L);
            end
         end
         ST_GAP: begin
            if (gap_q == '0) begin
               state_nx = ST_IDLE;
            end else begin
               gap_nx = gap_q - GONE_L;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_serial_pattern_tx                                            |
// | Brief  : Directed self-checking bench for serial_pattern_tx. One DUT     |
// |          uses GAP=2, a second uses GAP=0 for back-to-back framing.       |
// |          Outputs are sampled on the falling clock edge; "cycle k+i" is   |
// |          the i-th falling edge after acceptance edge k.                  |
// | Rev    : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_serial_pattern_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] load_data = 8'h00;
   logic [3:0] load_len = 4'd0;
   logic       x, x_valid, frame_done;

   logic       load_valid0 = 1'b0;
   logic       load_ready0;
   logic [7:0] load_data0 = 8'h00;
   logic [3:0] load_len0 = 4'd0;
   logic       x0, x_valid0, frame_done0;

   int n_vec = 0;
   int n_err = 0;

   // {load_ready, x_valid, x, frame_done}
   logic [3:0] obs, obs0;
   assign obs  = {load_ready, x_valid, x, frame_done};
   assign obs0 = {load_ready0, x_valid0, x0, frame_done0};

   always #5 clk = ~clk;

   serial_pattern_tx #(.WIDTH(8), .GAP(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .x          (x),
      .x_valid    (x_valid),
      .frame_done (frame_done)
   );

   serial_pattern_tx #(.WIDTH(8), .GAP(0)) dut0 (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid0),
      .load_ready (load_ready0),
      .load_data  (load_data0),
      .load_len   (load_len0),
      .x          (x0),
      .x_valid    (x_valid0),
      .frame_done (frame_done0)
   );

   // Offer one frame to the GAP=2 DUT and withdraw it just after the edge.
   task automatic accept(input logic [7:0] d, input logic [3:0] l);
      load_data  = d;
      load_len   = l;
      load_valid = 1'b1;
      @(posedge clk);
      #1 load_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #2;
      n_vec++;
      if (obs !== 4'b1000) begin
         n_err++; $display("FAIL reset_async: got %b want %b", obs, 4'b1000);
      end
      n_vec++;
      if (obs0 !== 4'b1000) begin
         n_err++; $display("FAIL reset_async_gap0: got %b want %b", obs0, 4'b1000);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (obs !== 4'b1000) begin
         n_err++; $display("FAIL reset_held: got %b want %b", obs, 4'b1000);
      end
      #5 reset = 1'b1;   // released 10 ns after assertion
   endtask

   task automatic test_basic();
      logic [7:0] pat;
      logic [3:0] exp;
      pat = 8'b1011_0010;
      n_vec++;
      if (load_ready !== 1'b1) begin
         n_err++; $display("FAIL basic_ready_pre: got %b want 1", load_ready);
      end
      accept(pat, 4'd8);
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         if (i <= 8)       exp = {1'b0, 1'b1, pat[8-i], (i == 8)};
         else if (i <= 10) exp = 4'b0000;
         else              exp = 4'b1000;
         n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL basic cyc k+%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_short();
      logic [7:0] pat;
      logic [3:0] exp;
      pat = 8'hF5;
      accept(pat, 4'd3);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i <= 3)      exp = {1'b0, 1'b1, pat[3-i], (i == 3)};
         else if (i <= 5) exp = 4'b0000;
         else             exp = 4'b1000;
         n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL short cyc k+%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_len_clamp();
      logic [7:0] pats [2];
      logic [3:0] lens [2];
      logic [7:0] pat;
      logic [3:0] exp;
      pats[0] = 8'h3C; lens[0] = 4'd0;
      pats[1] = 8'hA6; lens[1] = 4'd12;
      for (int f = 0; f < 2; f++) begin
         pat = pats[f];
         accept(pat, lens[f]);
         for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i <= 8)       exp = {1'b0, 1'b1, pat[8-i], (i == 8)};
            else if (i <= 10) exp = 4'b0000;
            else              exp = 4'b1000;
            n_vec++;
            if (obs !== exp) begin
               n_err++;
               $display("FAIL clamp len=%0d cyc k+%0d: got %b want %b", lens[f], i, obs, exp);
            end
         end
      end
   endtask

   task automatic test_hold_valid();
      logic [7:0] pat1, pat2;
      logic [3:0] exp;
      pat1 = 8'h96;   // low 5 bits 10110
      pat2 = 8'h5A;
      load_data  = pat1;
      load_len   = 4'd5;
      load_valid = 1'b1;
      @(posedge clk);
      #1 load_data = 8'h00;
      load_len = 4'd8;
      for (int i = 1; i <= 19; i++) begin
         @(negedge clk);
         if (i <= 5)       exp = {1'b0, 1'b1, pat1[5-i], (i == 5)};
         else if (i <= 7)  exp = 4'b0000;
         else if (i == 8)  exp = 4'b1000;
         else if (i <= 16) exp = {1'b0, 1'b1, pat2[16-i], (i == 16)};
         else if (i <= 18) exp = 4'b0000;
         else              exp = 4'b1000;
         n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL hold_valid cyc k+%0d: got %b want %b", i, obs, exp);
         end
         if (i < 8) begin
            load_data = 8'(i * 37);
            load_len  = 4'(i);
         end else if (i == 8) begin
            load_data = pat2;
            load_len  = 4'd8;
         end else if (i == 9) begin
            load_valid = 1'b0;
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] pat;
      logic [3:0] exp;
      accept(8'hFF, 4'd8);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_vec++;
         if (obs !== 4'b0110) begin
            n_err++; $display("FAIL areset_pre cyc k+%0d: got %b want %b", i, obs, 4'b0110);
         end
      end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if (obs !== 4'b1000) begin
         n_err++; $display("FAIL areset_immediate: got %b want %b", obs, 4'b1000);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (obs !== 4'b1000) begin
         n_err++; $display("FAIL areset_held: got %b want %b", obs, 4'b1000);
      end
      #2 reset = 1'b1;
      pat = 8'h01;   // low 2 bits 01
      accept(pat, 4'd2);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i <= 2)      exp = {1'b0, 1'b1, pat[2-i], (i == 2)};
         else if (i <= 4) exp = 4'b0000;
         else             exp = 4'b1000;
         n_vec++;
         if (obs !== exp) begin
            n_err++; $display("FAIL areset_post cyc k+%0d: got %b want %b", i, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] pat1, pat2;
      logic [3:0] exp;
      pat1 = 8'hA5;   // low 4 bits 0101
      pat2 = 8'h0B;   // low 4 bits 1011
      n_vec++;
      if (load_ready0 !== 1'b1) begin
         n_err++; $display("FAIL b2b_ready_pre: got %b want 1", load_ready0);
      end
      load_data0  = pat1;
      load_len0   = 4'd4;
      load_valid0 = 1'b1;
      @(posedge clk);
      #1 load_data0 = pat2;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i <= 4)      exp = {1'b0, 1'b1, pat1[4-i], (i == 4)};
         else if (i == 5) exp = 4'b1000;
         else if (i <= 9) exp = {1'b0, 1'b1, pat2[9-i], (i == 9)};
         else             exp = 4'b1000;
         n_vec++;
         if (obs0 !== exp) begin
            n_err++; $display("FAIL b2b_gap0 cyc k+%0d: got %b want %b", i, obs0, exp);
         end
         if (i == 6) load_valid0 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_len_clamp();
      test_hold_valid();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
